vita_tx_scheduler: RTL and testbench

Scheduler that sits on the sample-FIFO output of the VITA TX deframer and releases transmit samples to the DSP chain. It holds each burst until its timestamp matches the current VITA time, then paces consumption with the DSP `strobe`. It detects late bursts and underruns, reports them as error codes, and flushes the remainder of a faulty burst so the next burst starts clean.

---
 rtl/vita_tx_scheduler_pkg.sv | 30 +++
 rtl/vita_tx_scheduler_setting_reg.sv | 43 ++++
 rtl/vita_tx_scheduler.sv | 147 ++++++++++++++
 tb/tb_vita_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vita_tx_scheduler_pkg.sv
// vita_tx_scheduler_pkg
// Shared definitions for the VITA TX scheduler: FSM state encoding,
// bit offsets of the fields inside a sample-FIFO line, error codes and
// the saturating error-counter increment.
package vita_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Sample-FIFO line layout, LSB upward
    localparam int TIME_LSB     = 0;
    localparam int FLD_EOF      = 64;
    localparam int FLD_EOB      = 65;
    localparam int FLD_SOB      = 66;
    localparam int FLD_HAS_TIME = 67;
    localparam int SAMP_LSB     = 68;

    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_UNDERRUN = 4'd1;
    localparam logic [3:0] ERR_LATE     = 4'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vita_tx_scheduler_setting_reg.sv
// setting_reg
// One settings-bus register. Captures data_i when strobe_i is high and
// addr_i matches MY_ADDR; changed_o pulses for one cycle on each write.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   strobe_i            settings-bus write strobe
//   addr_i  [7:0]       settings-bus address
//   data_i  [WIDTH-1:0] settings-bus data (low WIDTH bits)
//   out_o   [WIDTH-1:0] register value
//   changed_o           one-cycle pulse after a write
module setting_reg #(
    parameter logic [7:0]       MY_ADDR  = 8'd0,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe_i,
    input  logic [7:0]       addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] out_o,
    output logic             changed_o
);

    logic [WIDTH-1:0] val_q;
    logic             changed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q     <= AT_RESET;
            changed_q <= 1'b0;
        end else if (strobe_i && (addr_i == MY_ADDR)) begin
            val_q     <= data_i;
            changed_q <= 1'b1;
        end else begin
            changed_q <= 1'b0;
        end
    end

    assign out_o     = val_q;
    assign changed_o = changed_q;

endmodule

// File: rtl/vita_tx_scheduler.sv
// vita_tx_scheduler
// Holds each TX burst at the head of the sample FIFO until its timestamp
// equals the current VITA time, then releases one line per DSP strobe.
// Late bursts and underruns are reported and the rest of the faulty burst
// is flushed so the next burst starts clean.
// Ports:
//   clk, reset, clear        clock, sync active-high reset, sync soft reset
//   set_stb/addr/data        settings bus (BASE+0 bit0 = late_policy)
//   vita_time [63:0]         current time {secs, tics}
//   sample_fifo_i            FIFO head line {samples, has_time, sob, eob, eof, time}
//   sample_fifo_src_rdy_i    head line valid
//   sample_fifo_dst_rdy_o    pop head line
//   strobe                   DSP requests one sample line
//   sample_o                 samples to DSP, zero when not releasing
//   run                      burst active
//   error, error_code        one-cycle error pulse, last error code
//   err_count                saturating error counter
module vita_tx_scheduler
    import vita_tx_scheduler_pkg::*;
#(
    parameter logic [7:0] BASE    = 8'd0,
    parameter int         MAXCHAN = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          set_stb,
    input  logic [7:0]                    set_addr,
    input  logic [31:0]                   set_data,
    input  logic [63:0]                   vita_time,
    input  logic [SAMP_LSB+32*MAXCHAN-1:0] sample_fifo_i,
    input  logic                          sample_fifo_src_rdy_i,
    output logic                          sample_fifo_dst_rdy_o,
    input  logic                          strobe,
    output logic [32*MAXCHAN-1:0]         sample_o,
    output logic                          run,
    output logic                          error,
    output logic [3:0]                    error_code,
    output logic [15:0]                   err_count
);

    logic        late_policy;
    logic        policy_changed_unused;
    logic        unused_fields;

    setting_reg #(
        .MY_ADDR (BASE),
        .WIDTH   (1),
        .AT_RESET(1'b0)
    ) u_policy (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (set_stb),
        .addr_i   (set_addr),
        .data_i   (set_data[0:0]),
        .out_o    (late_policy),
        .changed_o(policy_changed_unused)
    );

    logic [63:0]            line_time;
    logic                   line_eob;
    logic                   line_has_time;
    logic [32*MAXCHAN-1:0]  line_samples;

    assign line_time     = sample_fifo_i[TIME_LSB +: 64];
    assign line_eob      = sample_fifo_i[FLD_EOB];
    assign line_has_time = sample_fifo_i[FLD_HAS_TIME];
    assign line_samples  = sample_fifo_i[SAMP_LSB +: 32*MAXCHAN];

    // eof and sob carry no meaning for scheduling; sob is implied by IDLE
    assign unused_fields = ^{sample_fifo_i[FLD_EOF], sample_fifo_i[FLD_SOB],
                             set_data[31:1], policy_changed_unused};

    state_t      state_q;
    logic        error_q;
    logic [3:0]  error_code_q;
    logic [15:0] err_count_q;

    logic        time_match;
    logic        time_late;
    logic        err_det;
    logic [3:0]  err_det_code;

    assign time_match = (vita_time == line_time);
    assign time_late  = (vita_time > line_time);

    always_comb begin
        err_det      = 1'b0;
        err_det_code = ERR_NONE;
        case (state_q)
            ST_WAIT: if (sample_fifo_src_rdy_i && !time_match && time_late) begin
                err_det      = 1'b1;
                err_det_code = ERR_LATE;
            end
            // a strobe finding no head line is an underrun; a strobe that
            // pops the eob line ends the burst cleanly instead
            ST_RUN: if (strobe && !sample_fifo_src_rdy_i) begin
                err_det      = 1'b1;
                err_det_code = ERR_UNDERRUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q      <= ST_IDLE;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
            err_count_q  <= 16'd0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (sample_fifo_src_rdy_i)
                    state_q <= line_has_time ? ST_WAIT : ST_RUN;
                ST_WAIT: if (sample_fifo_src_rdy_i) begin
                    if (time_match)
                        state_q <= ST_RUN;
                    else if (time_late)
                        state_q <= late_policy ? ST_RUN : ST_ERROR;
                end
                ST_RUN: if (strobe) begin
                    if (!sample_fifo_src_rdy_i)
                        state_q <= ST_ERROR;
                    else if (line_eob)
                        state_q <= ST_IDLE;
                end
                ST_ERROR: if (sample_fifo_src_rdy_i && line_eob)
                    state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            if (err_det) begin
                error_q      <= 1'b1;
                error_code_q <= err_det_code;
                err_count_q  <= sat_inc16(err_count_q);
            end
        end
    end

    assign run                   = (state_q == ST_RUN);
    assign sample_fifo_dst_rdy_o = ((state_q == ST_RUN) && strobe) || (state_q == ST_ERROR);
    assign sample_o              = ((state_q == ST_RUN) && sample_fifo_src_rdy_i) ? line_samples : '0;
    assign error                 = error_q;
    assign error_code            = error_code_q;
    assign err_count             = err_count_q;

endmodule

// File: tb/tb_vita_tx_scheduler.sv
module tb_vita_tx_scheduler;

    localparam int LW = 100;

    logic          clk = 1'b0;
    logic          reset, clear, set_stb, strobe;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic [63:0]   vita_time;
    logic [LW-1:0] sample_fifo_i;
    logic          sample_fifo_src_rdy_i;
    logic          sample_fifo_dst_rdy_o;
    logic [31:0]   sample_o;
    logic          run, error;
    logic [3:0]    error_code;
    logic [15:0]   err_count;

    vita_tx_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .clear                (clear),
        .set_stb              (set_stb),
        .set_addr             (set_addr),
        .set_data             (set_data),
        .vita_time            (vita_time),
        .sample_fifo_i        (sample_fifo_i),
        .sample_fifo_src_rdy_i(sample_fifo_src_rdy_i),
        .sample_fifo_dst_rdy_o(sample_fifo_dst_rdy_o),
        .strobe               (strobe),
        .sample_o             (sample_o),
        .run                  (run),
        .error                (error),
        .error_code           (error_code),
        .err_count            (err_count)
    );

    always #5 clk = ~clk;

    // FIFO model, delivery monitor and expectation queues
    logic [LW-1:0] fifo_q[$];
    logic [31:0]   deliv_q[$];
    logic [31:0]   exp_q[$];
    logic [3:0]    err_q[$];
    logic [3:0]    exp_err_q[$];
    logic          vt_inc;
    int            run_cnt;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [LW-1:0] mk_line(input logic ht, input logic sob, input logic eob,
                                              input logic eof, input logic [63:0] t,
                                              input logic [31:0] s);
        return {s, ht, sob, eob, eof, t};
    endfunction

    task automatic drive();
        sample_fifo_src_rdy_i = (fifo_q.size() != 0);
        sample_fifo_i         = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    // Ends the current cycle: observes settled outputs at the negedge,
    // then applies the FIFO pop and time advance after the posedge.
    task automatic cyc();
        logic pop_now;
        @(negedge clk);
        pop_now = sample_fifo_dst_rdy_o && sample_fifo_src_rdy_i;
        if (pop_now && run) deliv_q.push_back(sample_o);
        if (error) err_q.push_back(error_code);
        if (run) run_cnt++;
        @(posedge clk);
        #1;
        if (pop_now) void'(fifo_q.pop_front());
        if (vt_inc) vita_time = vita_time + 64'd1;
        drive();
        #1;
    endtask

    task automatic clr_mon();
        deliv_q.delete(); exp_q.delete(); err_q.delete(); exp_err_q.delete();
        run_cnt = 0;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        drive();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic set_policy(input logic p);
        set_stb = 1'b1; set_addr = 8'd0; set_data = {31'd0, p};
        cyc();
        set_stb = 1'b0; set_data = 32'd0;
    endtask

    task automatic drain(input string tag, input int bound, input bit rand_strobe);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || run) && n < bound) begin
            if (rand_strobe) strobe = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        check({tag, "_drain_timeout"}, 64'(n >= bound), 64'd0);
    endtask

    task automatic cmp_deliv(input string tag);
        check({tag, "_deliv_count"}, 64'(deliv_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < deliv_q.size(); i++)
            check($sformatf("%s_deliv%0d", tag, i), 64'(deliv_q[i]), 64'(exp_q[i]));
    endtask

    task automatic cmp_err(input string tag);
        check({tag, "_err_pulses"}, 64'(err_q.size()), 64'(exp_err_q.size()));
        for (int i = 0; i < exp_err_q.size() && i < err_q.size(); i++)
            check($sformatf("%s_err%0d", tag, i), 64'(err_q[i]), 64'(exp_err_q[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit          got_run;
        logic [63:0] rise_t;
        logic [31:0] s;
        logic        pol;
        int          nl, kind;
        logic [63:0] t0, send;
        int          model_cnt;

        reset = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        strobe = 1'b0; vita_time = 64'd0; vt_inc = 1'b0;
        clr_mon();
        do_reset();

        check("rst_run", 64'(run), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_error_code", 64'(error_code), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_sample_o", 64'(sample_o), 64'd0);
        check("rst_dst_rdy", 64'(sample_fifo_dst_rdy_o), 64'd0);

        // 1: untimed single line, strobe held
        clr_mon();
        strobe = 1'b1;
        fifo_q.push_back(mk_line(1'b0, 1'b1, 1'b1, 1'b1, 64'd0, 32'hDEADBEEF));
        drive();
        check("t1_idle_run", 64'(run), 64'd0);
        check("t1_idle_nopop", 64'(sample_fifo_dst_rdy_o), 64'd0);
        cyc();
        check("t1_run_rise", 64'(run), 64'd1);
        check("t1_sample", 64'(sample_o), 64'hDEADBEEF);
        cyc();
        check("t1_run_fall", 64'(run), 64'd0);
        check("t1_sample_zero", 64'(sample_o), 64'd0);
        check("t1_deliv", 64'(deliv_q.size()), 64'd1);
        check("t1_no_error", 64'(err_q.size()), 64'd0);

        // 2: timed 4-line burst, vita_time ramping from 990 to 1000
        clr_mon();
        vita_time = 64'd990; vt_inc = 1'b1; strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = $urandom;
            fifo_q.push_back(mk_line(i == 0, i == 0, i == 3, 1'b0, 64'd1000, s));
            exp_q.push_back(s);
        end
        drive();
        got_run = 1'b0; rise_t = '0;
        for (int i = 0; i < 40 && !got_run; i++) begin
            cyc();
            if (run) begin got_run = 1'b1; rise_t = vita_time; end
        end
        check("t2_run_seen", 64'(got_run), 64'd1);
        check("t2_run_time", rise_t, 64'd1001);
        check("t2_no_early_pop", 64'(deliv_q.size()), 64'd0);
        drain("t2", 40, 1'b0);
        cmp_deliv("t2");
        check("t2_no_error", 64'(err_q.size()), 64'd0);
        vt_inc = 1'b0;

        // 3: late burst, drop policy
        clr_mon();
        vita_time = 64'd600;
        for (int i = 0; i < 3; i++)
            fifo_q.push_back(mk_line(i == 0, i == 0, i == 2, 1'b0, 64'd500, $urandom));
        drive();
        exp_err_q.push_back(4'd2);
        drain("t3", 30, 1'b0);
        cmp_err("t3");
        check("t3_error_code", 64'(error_code), 64'd2);
        check("t3_err_count", 64'(err_count), 64'd1);
        check("t3_run_never", 64'(run_cnt), 64'd0);
        check("t3_flushed", 64'(fifo_q.size()), 64'd0);
        cmp_deliv("t3");
        check("t3_idle_dst_rdy", 64'(sample_fifo_dst_rdy_o), 64'd0);

        // 4: late burst, send-anyway policy
        do_reset();
        set_policy(1'b1);
        clr_mon();
        for (int i = 0; i < 2; i++) begin
            s = $urandom;
            fifo_q.push_back(mk_line(i == 0, i == 0, i == 1, 1'b0, 64'd500, s));
            exp_q.push_back(s);
        end
        drive();
        exp_err_q.push_back(4'd2);
        drain("t4", 30, 1'b0);
        cmp_err("t4");
        check("t4_error_code", 64'(error_code), 64'd2);
        check("t4_err_count", 64'(err_count), 64'd1);
        check("t4_run_seen", 64'(run_cnt != 0), 64'd1);
        cmp_deliv("t4");
        set_policy(1'b0);

        // 5: underrun, flush, then a clean burst
        clr_mon();
        for (int i = 0; i < 3; i++) begin
            s = $urandom;
            fifo_q.push_back(mk_line(1'b0, i == 0, 1'b0, 1'b0, 64'd0, s));
            exp_q.push_back(s);
        end
        drive();
        for (int i = 0; i < 20 && !error; i++) cyc();
        check("t5_error_pulse", 64'(error), 64'd1);
        check("t5_error_code", 64'(error_code), 64'd1);
        check("t5_err_count", 64'(err_count), 64'd2);
        check("t5_run_off", 64'(run), 64'd0);
        check("t5_pops_before", 64'(deliv_q.size()), 64'd3);
        fifo_q.push_back(mk_line(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'h5A5A5A5A));
        drive();
        drain("t5_flush", 10, 1'b0);
        cyc();
        check("t5_flush_not_sent", 64'(deliv_q.size()), 64'd3);
        for (int i = 0; i < 2; i++) begin
            s = $urandom;
            fifo_q.push_back(mk_line(1'b0, i == 0, i == 1, 1'b0, 64'd0, s));
            exp_q.push_back(s);
        end
        drive();
        drain("t5_next", 20, 1'b0);
        cmp_deliv("t5");
        check("t5_err_count_final", 64'(err_count), 64'd2);

        // 6: clear in the middle of a burst
        clr_mon();
        strobe = 1'b0;
        for (int i = 0; i < 3; i++)
            fifo_q.push_back(mk_line(1'b0, i == 0, i == 2, 1'b0, 64'd0, $urandom));
        drive();
        cyc();
        check("t6_run", 64'(run), 64'd1);
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        check("t6_pending", 64'(fifo_q.size()), 64'd2);
        clear = 1'b1;
        cyc();
        check("t6_clear_run", 64'(run), 64'd0);
        check("t6_clear_sample", 64'(sample_o), 64'd0);
        check("t6_clear_code", 64'(error_code), 64'd0);
        check("t6_clear_count", 64'(err_count), 64'd0);
        check("t6_clear_dst_rdy", 64'(sample_fifo_dst_rdy_o), 64'd0);
        clear = 1'b0;
        fifo_q.delete();
        drive();
        cyc();

        // Random bursts against a burst-level outcome model; time crosses a
        // 32-bit boundary of the 64-bit counter during the run
        do_reset();
        clr_mon();
        vita_time = 64'h0000_0001_FFFF_FF00; vt_inc = 1'b1;
        model_cnt = 0;
        for (int b = 0; b < 25; b++) begin
            pol = 1'($urandom_range(0, 1));
            set_policy(pol);
            nl   = $urandom_range(1, 4);
            kind = $urandom_range(0, 2);
            t0   = vita_time;
            if (kind == 2) send = t0 - 64'($urandom_range(1, 50));
            else           send = t0 + 64'($urandom_range(3, 30));
            for (int i = 0; i < nl; i++) begin
                s = $urandom;
                if (i == 0)
                    fifo_q.push_back(mk_line(kind != 0, 1'b1, nl == 1, 1'b0, send, s));
                else
                    fifo_q.push_back(mk_line(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                             i == nl - 1, 1'($urandom_range(0, 1)),
                                             {$urandom, $urandom}, s));
                if (!(kind == 2 && pol == 1'b0)) exp_q.push_back(s);
            end
            if (kind == 2) begin
                exp_err_q.push_back(4'd2);
                model_cnt++;
            end
            drive();
            drain($sformatf("rnd%0d", b), 300, 1'b1);
        end
        strobe = 1'b0;
        cyc();
        cmp_deliv("rnd");
        cmp_err("rnd");
        check("rnd_err_count", 64'(err_count), 64'(model_cnt));
        check("rnd_end_run", 64'(run), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
